// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Shared definitions for the MIPS architectural register bank:
//   NB_REG       - register / data width in bits
//   NB_REG_ADDR  - register index width
//   ZERO_REG     - index of the hardwired-zero register
//   dump_state_t - encoding of the debug dump FSM (IDLE, SEND, DONE)
// ---------------------------------------------------------------------------
package register_file_pkg;

    localparam int NB_REG      = 32;
    localparam int NB_REG_ADDR = 5;
    localparam int ZERO_REG    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_dump_ctrl
// Streams every register out to the debug/UART unit, one word per
// valid/ready handshake, then pulses o_dump_done for one cycle.
// Ports:
//   i_clock, i_reset     - clock, asynchronous active-low reset
//   i_dump_start         - single-cycle dump request (honoured only in IDLE)
//   i_dbg_ready          - consumer accepts the presented word
//   i_rd_data            - array contents at o_rd_addr (no write bypass)
//   o_rd_addr            - index of the word to load on the next edge
//   o_dbg_data/o_dbg_addr- presented word and its index (registered)
//   o_dbg_valid          - presented word is valid
//   o_dump_done          - one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module regfile_dump_ctrl #(
    parameter int NB_REG      = 32,
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_dump_start,
    input  logic                   i_dbg_ready,
    input  logic [NB_REG-1:0]      i_rd_data,
    output logic [NB_REG_ADDR-1:0] o_rd_addr,
    output logic [NB_REG-1:0]      o_dbg_data,
    output logic [NB_REG_ADDR-1:0] o_dbg_addr,
    output logic                   o_dbg_valid,
    output logic                   o_dump_done
);
    import register_file_pkg::*;

    localparam logic [NB_REG_ADDR-1:0] LAST_IDX = '1;

    dump_state_t            state;
    logic [NB_REG_ADDR-1:0] index;
    logic [NB_REG_ADDR-1:0] next_index;

    assign next_index = index + NB_REG_ADDR'(1);

    // The word loaded on the next edge: word 0 when a dump starts, otherwise
    // the successor of the word currently presented.
    assign o_rd_addr = (state == IDLE) ? '0 : next_index;

    // Dump FSM with registered outputs; the presented word is frozen until
    // the consumer accepts it, so later writes to that register are not seen.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            index       <= '0;
            o_dbg_data  <= '0;
            o_dbg_addr  <= '0;
            o_dbg_valid <= 1'b0;
            o_dump_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        index       <= '0;
                        o_dbg_addr  <= '0;
                        o_dbg_data  <= i_rd_data;
                        o_dbg_valid <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (i_dbg_ready) begin
                        if (index == LAST_IDX) begin
                            o_dbg_valid <= 1'b0;
                            o_dump_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            index      <= next_index;
                            o_dbg_addr <= next_index;
                            o_dbg_data <= i_rd_data;
                        end
                    end
                end
                DONE: begin
                    o_dump_done <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    o_dbg_valid <= 1'b0;
                    o_dump_done <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// Architectural register bank at the end of the write-back path. Two
// combinational read ports (rs, rt) with same-cycle write-to-read bypass,
// register 0 hardwired to zero, and a debug dump port.
// Ports:
//   i_clock, i_reset           - clock, asynchronous active-low reset
//   i_wb_data, i_reg_dest,
//   i_reg_we                   - write-back data, destination, enable
//   i_rs_addr / o_rs_data      - read port A
//   i_rt_addr / o_rt_data      - read port B
//   i_dump_start, i_dbg_ready  - dump request, consumer ready
//   o_dbg_data, o_dbg_addr,
//   o_dbg_valid, o_dump_done   - dumped word, its index, valid, completion
// ---------------------------------------------------------------------------
module register_file #(
    parameter int NB_REG      = register_file_pkg::NB_REG,
    parameter int NB_REG_ADDR = register_file_pkg::NB_REG_ADDR
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_REG-1:0]      i_wb_data,
    input  logic [NB_REG_ADDR-1:0] i_reg_dest,
    input  logic                   i_reg_we,
    input  logic [NB_REG_ADDR-1:0] i_rs_addr,
    input  logic [NB_REG_ADDR-1:0] i_rt_addr,
    output logic [NB_REG-1:0]      o_rs_data,
    output logic [NB_REG-1:0]      o_rt_data,
    input  logic                   i_dump_start,
    input  logic                   i_dbg_ready,
    output logic [NB_REG-1:0]      o_dbg_data,
    output logic [NB_REG_ADDR-1:0] o_dbg_addr,
    output logic                   o_dbg_valid,
    output logic                   o_dump_done
);
    import register_file_pkg::*;

    localparam int N_REGS = 2 ** NB_REG_ADDR;

    logic [NB_REG-1:0]      regs [N_REGS];
    logic [NB_REG_ADDR-1:0] dump_rd_addr;
    logic                   write_en;

    // Writes aimed at register 0 are dropped, so its storage stays zero
    // and the bypass below can never forward into it either.
    assign write_en = i_reg_we && (i_reg_dest != NB_REG_ADDR'(ZERO_REG));

    // Array storage, cleared asynchronously on reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[i_reg_dest] <= i_wb_data;
        end
    end

    // Read ports forward the value being retired so decode never sees a
    // stale operand in the write cycle.
    always_comb begin
        o_rs_data = regs[i_rs_addr];
        o_rt_data = regs[i_rt_addr];
        if (write_en && (i_reg_dest == i_rs_addr)) begin
            o_rs_data = i_wb_data;
        end
        if (write_en && (i_reg_dest == i_rt_addr)) begin
            o_rt_data = i_wb_data;
        end
    end

    regfile_dump_ctrl #(
        .NB_REG      (NB_REG),
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_dump_ctrl (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dbg_ready  (i_dbg_ready),
        .i_rd_data    (regs[dump_rd_addr]),
        .o_rd_addr    (dump_rd_addr),
        .o_dbg_data   (o_dbg_data),
        .o_dbg_addr   (o_dbg_addr),
        .o_dbg_valid  (o_dbg_valid),
        .o_dump_done  (o_dump_done)
    );

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Directed self-checking bench for register_file: reset state, writes,
// register 0, same-cycle bypass, full dump, backpressure with concurrent
// writes, ignored restart and reset mid-dump.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int N_REGS = 32;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_wb_data;
    logic [4:0]  i_reg_dest;
    logic        i_reg_we;
    logic [4:0]  i_rs_addr;
    logic [4:0]  i_rt_addr;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic        i_dump_start;
    logic        i_dbg_ready;
    logic [31:0] o_dbg_data;
    logic [4:0]  o_dbg_addr;
    logic        o_dbg_valid;
    logic        o_dump_done;

    int          check_count = 0;
    int          error_count = 0;
    logic [31:0] model [N_REGS];

    register_file dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_wb_data    (i_wb_data),
        .i_reg_dest   (i_reg_dest),
        .i_reg_we     (i_reg_we),
        .i_rs_addr    (i_rs_addr),
        .i_rt_addr    (i_rt_addr),
        .o_rs_data    (o_rs_data),
        .o_rt_data    (o_rt_data),
        .i_dump_start (i_dump_start),
        .i_dbg_ready  (i_dbg_ready),
        .o_dbg_data   (o_dbg_data),
        .o_dbg_addr   (o_dbg_addr),
        .o_dbg_valid  (o_dbg_valid),
        .o_dump_done  (o_dump_done)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of pipeline inputs 1ns after the rising edge.
    task automatic applyStimulus(input logic we, input logic [4:0] dest,
                                 input logic [31:0] data, input logic [4:0] rs,
                                 input logic [4:0] rt);
        @(posedge i_clock);
        #1;
        i_reg_we   = we;
        i_reg_dest = dest;
        i_wb_data  = data;
        i_rs_addr  = rs;
        i_rt_addr  = rt;
    endtask

    task automatic writeReg(input logic [4:0] dest, input logic [31:0] data);
        applyStimulus(1'b1, dest, data, 5'd0, 5'd0);
        if (dest != 5'd0) model[dest] = data;
    endtask

    // Runs one dump with ready high except for a 3-cycle stall at stall_at
    // (writing reg4 and reg9 during it), optionally re-pulsing start when
    // restart_at is reached, or asserting reset when abort_at is presented.
    task automatic runDump(input int stall_at, input int abort_at, input int restart_at);
        int          exp_addr = 0;
        int          guard    = 0;
        int          stalls   = 0;
        bit          new_word = 1'b1;
        bit          aborted  = 1'b0;
        logic [31:0] exp_data = '0;

        @(posedge i_clock);
        #1;
        i_reg_we     = 1'b0;
        i_dump_start = 1'b1;
        i_dbg_ready  = 1'b1;
        @(posedge i_clock);
        #1;
        i_dump_start = 1'b0;

        while (exp_addr < N_REGS && !aborted && guard < 200) begin
            #3;
            if (new_word) begin
                exp_data = model[exp_addr];
                new_word = 1'b0;
            end
            checkOutput("dbg_valid", 32'(o_dbg_valid), 32'd1);
            checkOutput("dbg_addr", 32'(o_dbg_addr), 32'(exp_addr));
            checkOutput("dbg_data", o_dbg_data, exp_data);
            checkOutput("dump_done_early", 32'(o_dump_done), 32'd0);
            if (exp_addr == abort_at) begin
                i_reset   = 1'b0;
                #1;
                checkOutput("abort_valid", 32'(o_dbg_valid), 32'd0);
                checkOutput("abort_done", 32'(o_dump_done), 32'd0);
                checkOutput("abort_dbg_data", o_dbg_data, 32'd0);
                checkOutput("abort_dbg_addr", 32'(o_dbg_addr), 32'd0);
                i_rs_addr = 5'd7;
                i_rt_addr = 5'd31;
                #1;
                checkOutput("abort_rs", o_rs_data, 32'd0);
                checkOutput("abort_rt", o_rt_data, 32'd0);
                for (int k = 0; k < N_REGS; k++) model[k] = '0;
                aborted = 1'b1;
            end else if (exp_addr == stall_at && stalls < 3) begin
                i_dbg_ready = 1'b0;
                if (stalls == 0) begin
                    i_reg_we   = 1'b1;
                    i_reg_dest = 5'd4;
                    i_wb_data  = 32'h4444_4444;
                    model[4]   = 32'h4444_4444;
                end else if (stalls == 1) begin
                    i_reg_we   = 1'b1;
                    i_reg_dest = 5'd9;
                    i_wb_data  = 32'h9999_9999;
                    model[9]   = 32'h9999_9999;
                end
                stalls++;
            end else begin
                i_dbg_ready = 1'b1;
                exp_addr++;
                new_word = 1'b1;
                if (exp_addr == restart_at) i_dump_start = 1'b1;
            end
            @(posedge i_clock);
            #1;
            i_reg_we     = 1'b0;
            i_dump_start = 1'b0;
            guard++;
        end

        if (aborted) begin
            #2;
            i_reset = 1'b1;
            repeat (4) begin
                @(posedge i_clock);
                #4;
                checkOutput("post_abort_valid", 32'(o_dbg_valid), 32'd0);
                checkOutput("post_abort_done", 32'(o_dump_done), 32'd0);
            end
        end else if (exp_addr < N_REGS) begin
            checkOutput("dump_timeout", 32'(exp_addr), 32'(N_REGS));
        end else begin
            #3;
            checkOutput("done_pulse", 32'(o_dump_done), 32'd1);
            checkOutput("done_valid", 32'(o_dbg_valid), 32'd0);
            @(posedge i_clock);
            #4;
            checkOutput("done_single", 32'(o_dump_done), 32'd0);
            repeat (3) begin
                @(posedge i_clock);
                #4;
                checkOutput("idle_valid", 32'(o_dbg_valid), 32'd0);
            end
        end
    endtask

    initial begin
        i_reset      = 1'b0;
        i_wb_data    = '0;
        i_reg_dest   = '0;
        i_reg_we     = 1'b0;
        i_rs_addr    = 5'd5;
        i_rt_addr    = 5'd31;
        i_dump_start = 1'b0;
        i_dbg_ready  = 1'b0;
        for (int k = 0; k < N_REGS; k++) model[k] = '0;

        // Reset state
        #12;
        checkOutput("rst_rs", o_rs_data, 32'd0);
        checkOutput("rst_rt", o_rt_data, 32'd0);
        checkOutput("rst_valid", 32'(o_dbg_valid), 32'd0);
        checkOutput("rst_done", 32'(o_dump_done), 32'd0);
        checkOutput("rst_dbg_data", o_dbg_data, 32'd0);
        checkOutput("rst_dbg_addr", 32'(o_dbg_addr), 32'd0);
        i_reset = 1'b1;

        // Write reg7, bypass in the write cycle and array read afterwards
        applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd5);
        #3;
        checkOutput("wr7_bypass", o_rs_data, 32'hDEAD_BEEF);
        checkOutput("wr7_other", o_rt_data, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd31);
        #3;
        checkOutput("rd7", o_rs_data, 32'hDEAD_BEEF);
        checkOutput("rd31", o_rt_data, 32'd0);

        // Register 0 ignores writes
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #3;
        checkOutput("r0_wcycle_rs", o_rs_data, 32'd0);
        checkOutput("r0_wcycle_rt", o_rt_data, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #3;
        checkOutput("r0_after_rs", o_rs_data, 32'd0);
        checkOutput("r0_after_rt", o_rt_data, 32'd0);

        // Preload reg k = k*0x10
        for (int k = 1; k < N_REGS; k++) writeReg(5'(k), 32'(k * 16));

        // Same-cycle bypass on both ports, then the stored value with we=0
        applyStimulus(1'b1, 5'd12, 32'h1234_5678, 5'd12, 5'd12);
        #3;
        checkOutput("byp_rs", o_rs_data, 32'h1234_5678);
        checkOutput("byp_rt", o_rt_data, 32'h1234_5678);
        i_reg_we = 1'b0;
        #2;
        checkOutput("nobyp_rs", o_rs_data, 32'h0000_00C0);
        checkOutput("nobyp_rt", o_rt_data, 32'h0000_00C0);

        // Full dump, start re-pulsed mid-dump must not cause a second dump
        runDump(-1, -1, 5);

        // Backpressure at addr 4 with writes to reg4 and reg9 during the stall
        runDump(4, -1, -1);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd4, 5'd9);
        #3;
        checkOutput("rd4_after_dump", o_rs_data, 32'h4444_4444);
        checkOutput("rd9_after_dump", o_rt_data, 32'h9999_9999);

        // Reset while addr 10 is presented
        runDump(-1, 10, -1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register bank for the MIPS pipeline.
- It sits at the receiving end of the write-back path. It takes the destination index, write enable and write data produced by the write-back stage, and serves the two operand reads (rs, rt) for the decode stage.
- It provides write-to-read bypass in the same cycle, so decode always sees the value being retired.
- A debug dump port streams all registers out, one word per handshake, for the debug/UART unit.

Parameters:
- NB_REG, 32, register and data width in bits.
- NB_REG_ADDR, 5, register index width.
- N_REGS, 2**NB_REG_ADDR, number of registers. Derived; not overridden.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_wb_data  in  NB_REG  write data from write-back.
- i_reg_dest  in  NB_REG_ADDR  write destination index.
- i_reg_we  in  1  write enable.
- i_rs_addr  in  NB_REG_ADDR  read port A index.
- i_rt_addr  in  NB_REG_ADDR  read port B index.
- o_rs_data  out  NB_REG  read port A data.
- o_rt_data  out  NB_REG  read port B data.
- i_dump_start  in  1  single-cycle request to start a dump.
- i_dbg_ready  in  1  debug consumer ready.
- o_dbg_data  out  NB_REG  dumped register value.
- o_dbg_addr  out  NB_REG_ADDR  index of o_dbg_data.
- o_dbg_valid  out  1  o_dbg_data/o_dbg_addr valid.
- o_dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: i_reset low clears all N_REGS registers to 0 immediately, without waiting for a clock edge.
  - FSM goes to IDLE; dump index goes to 0.
  - o_dbg_valid=0, o_dump_done=0, o_dbg_data=0, o_dbg_addr=0.
  - o_rs_data/o_rt_data are 0, since they are combinational reads of a cleared array.
- Write: on a rising edge with i_reg_we=1 and i_reg_dest!=0, reg[i_reg_dest] <= i_wb_data.
- Register 0 is hardwired to 0. Writes to it are dropped and it always reads 0.
- Read latency is zero; reads are combinational. The rs and rt ports behave identically. For port rs:
  - If i_reg_we=1, i_reg_dest==i_rs_addr and i_rs_addr!=0, o_rs_data = i_wb_data (bypass).
  - Otherwise o_rs_data = reg[i_rs_addr].
- Both read ports may address the same register, including the write target, in the same cycle.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: o_dbg_valid=0. If i_dump_start=1, set index to 0 and go to SEND.
  - SEND:
    - o_dbg_valid=1, o_dbg_addr=index, o_dbg_data=reg[index], registered from the array with no bypass. A write in the same cycle is visible only once the edge has committed it.
    - Data and address are held stable while i_dbg_ready=0.
    - On i_dbg_ready=1 (the transfer cycle): if index==N_REGS-1, go to DONE; otherwise index+1 and load the next word on the next cycle.
    - A new word may be presented every cycle while ready stays high.
  - DONE: o_dump_done=1 for exactly one cycle, then return to IDLE.
- i_dump_start outside IDLE is ignored; there is no queueing or restart.
- Pipeline writes continue normally during a dump.
  - A word not yet presented reflects every write committed before its presentation cycle.
  - A presented word stays frozen until it is accepted.
- A reset mid-dump aborts the dump. No o_dump_done is produced and the array is cleared.
- Index arithmetic is NB_REG_ADDR wide. Wrap is never reached because SEND exits at N_REGS-1.

Decomposition:
- Shared package holds:
  - NB_REG, NB_REG_ADDR.
  - ZERO_REG index constant (0).
  - Dump FSM state encoding, 2 bits: IDLE, SEND, DONE.
- One natural sub-module, regfile_dump_ctrl: the FSM, the index counter, the valid/done generation, and the output data register.
- Array storage, write logic and read bypass stay in register_file.

Test Plan:
- Reset, then read rs=5, rt=31 -> both 0. Write reg7=0xDEADBEEF, then read rs=7 next cycle -> 0xDEADBEEF.
- Write reg0=0xFFFFFFFF with we=1, then read rs=0, rt=0 -> 0, in both the write cycle and the following cycle.
- Same-cycle bypass: we=1, dest=12, data=0x12345678, rs=12, rt=12 -> both outputs 0x12345678 in that cycle. With we=0 -> old value.
- Full dump with ready held high after reg k = k*0x10 is preloaded:
  - 32 consecutive valid cycles, addr 0..31, data 0x0,0x10,...,0x1F0.
  - o_dump_done high for exactly one cycle, the cycle after addr 31 is accepted.
- Backpressure and concurrent write:
  - Ready low for 3 cycles while addr 4 is presented -> data and addr held stable.
  - A write to reg4 during the stall does not change o_dbg_data.
  - A write to reg9 before its turn -> the new value is dumped.
- i_dump_start during SEND is ignored, giving a single dump of 32 words. Reset asserted at addr 10 -> valid=0 immediately, no done pulse, all reads 0.
